dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache controller for the MW stage of the RISC-V pipeline CPU. Serves CPU loads and stores in one cycle on a hit. On a miss it raises DCacheMiss, which the hazard unit uses to stall the pipeline. It then writes back a dirty victim line and refills the line over a word-serial memory handshake.

---
 rtl/dcache_ctrl_if.sv | 25 ++
 rtl/dcache_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side and memory-side signal bundle of the data cache
interface dcache_ctrl_if;
  logic        CpuRd;
  logic [3:0]  CpuWe;
  logic [31:0] CpuAddr;
  logic [31:0] CpuWData;
  logic [31:0] CpuRData;
  logic        DCacheMiss;
  logic        MemReq;
  logic        MemWr;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic [31:0] HitCount;
  logic [31:0] MissCount;
  modport master (
    output CpuRd, CpuWe, CpuAddr, CpuWData, MemAck, MemRData,
    input  CpuRData, DCacheMiss, MemReq, MemWr, MemAddr, MemWData, HitCount, MissCount
  );
  modport slave (
    input  CpuRd, CpuWe, CpuAddr, CpuWData, MemAck, MemRData,
    output CpuRData, DCacheMiss, MemReq, MemWr, MemAddr, MemWData, HitCount, MissCount
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with word-serial refill
module dcache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input logic          clk,
  input logic          CpuRstN,
  dcache_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t           state, state_nx;
  logic [OFF_W-1:0] beat;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [SETS-1:0]  valid, dirty;
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];
  logic             replay;
  logic [31:0]      hit_cnt, miss_cnt;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] word;
  logic             access, store, hit, miss, ack, last, fill_done;
  logic             unused_addr;
  assign tag         = bus.CpuAddr[31 -: TAG_W];
  assign idx         = bus.CpuAddr[2+OFF_W +: IDX_W];
  assign word        = bus.CpuAddr[2 +: OFF_W];
  assign unused_addr = ^bus.CpuAddr[1:0];
  // Lookup: hits and misses are only recognised in IDLE and never while reset is held
  always_comb begin
    store     = bus.CpuWe != '0;
    access    = bus.CpuRd || store;
    hit       = CpuRstN && state == IDLE && access && valid[idx] && tag_mem[idx] == tag;
    miss      = CpuRstN && state == IDLE && access && !hit;
    ack       = state != IDLE && bus.MemAck;
    last      = &beat;
    fill_done = state == FILL && ack && last;
  end
  // State register
  always_ff @(posedge clk or negedge CpuRstN) begin
    if (!CpuRstN) state <= IDLE;
    else state <= state_nx;
  end
  // Next state: a dirty victim is written back before the refill starts
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = miss ? (valid[idx] && dirty[idx] ? WB : FILL) : IDLE;
      WB:      state_nx = ack && last ? FILL : WB;
      FILL:    state_nx = ack && last ? IDLE : FILL;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs: memory beats use the latched miss index/tag so CPU address changes cannot disturb them
  always_comb begin
    bus.MemReq     = state != IDLE;
    bus.MemWr      = state == WB;
    bus.MemAddr    = state == WB   ? {tag_mem[miss_idx], miss_idx, beat, 2'b00} :
                     state == FILL ? {miss_tag, miss_idx, beat, 2'b00} : '0;
    bus.MemWData   = state == WB ? data_mem[miss_idx][beat] : '0;
    bus.DCacheMiss = state != IDLE || miss;
    bus.CpuRData   = hit && !store ? data_mem[idx][word] : '0;
    bus.HitCount   = hit_cnt;
    bus.MissCount  = miss_cnt;
  end
  // Line status, beat counter, miss latch and saturating statistics; the replayed hit is not counted
  always_ff @(posedge clk or negedge CpuRstN) begin
    if (!CpuRstN) begin
      beat     <= '0;
      valid    <= '0;
      dirty    <= '0;
      replay   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      replay <= fill_done;
      if (ack) beat <= beat + OFF_W'(1);
      if (miss) begin
        miss_idx <= idx;
        miss_tag <= tag;
        miss_cnt <= miss_cnt + 32'(~&miss_cnt);
      end
      if (hit && !replay) hit_cnt <= hit_cnt + 32'(~&hit_cnt);
      if (hit && store) dirty[idx] <= 1'b1;
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end
  // Tag and data arrays: refill beats and byte-masked store hits
  always_ff @(posedge clk) begin
    if (state == FILL && ack) data_mem[miss_idx][beat] <= bus.MemRData;
    if (fill_done) tag_mem[miss_idx] <= miss_tag;
    if (hit && store)
      for (int b = 0; b < 4; b++)
        if (bus.CpuWe[b]) data_mem[idx][word][8*b +: 8] <= bus.CpuWData[8*b +: 8];
  end
endmodule
